// File: rtl/output_trans_pkg.sv
// Shared constants, state encoding and int8 saturation for the Winograd
// F(2x2,3x3) output transform.
package output_trans_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;

  localparam int TILE_IN  = 4;
  localparam int TILE_OUT = 2;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_ROW = 2'd1,
    ST_COL = 2'd2,
    ST_OUT = 2'd3
  } state_t;

  function automatic logic [7:0] sat_int8(input logic signed [63:0] v);
    if (v > 64'(INT8_MAX)) begin
      return 8'(INT8_MAX);
    end else if (v < 64'(INT8_MIN)) begin
      return 8'(INT8_MIN);
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/output_trans_wino_1d_out.sv
// 1-D Winograd output transform A^T = [1 1 1 0; 0 1 -1 -1] on four signed
// inputs; outputs grow by two bits so no intermediate can overflow.
module wino_1d_out #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] y0,
  output logic signed [W+1:0] y1
);

  always_comb begin
    y0 = (W+2)'(a) + (W+2)'(b) + (W+2)'(c);
    y1 = (W+2)'(b) - (W+2)'(c) - (W+2)'(d);
  end

endmodule

// File: rtl/output_trans.sv
// Winograd F(2x2,3x3) output transform: accumulates 4x4 product tiles over
// channels, then applies A^T*M*A, requantises and emits a 2x2 int8 tile.
module output_trans
  import output_trans_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [16*PROD_W-1:0] in_data,
  input  logic [3:0]           shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data
);

  localparam int NUM_ELEM = TILE_IN * TILE_IN;

  state_t                  state;
  logic                    first;
  logic [3:0]              shift_q;
  logic signed [ACC_W-1:0] acc [NUM_ELEM];
  logic signed [ACC_W+1:0] t_d [TILE_OUT][TILE_IN];
  logic signed [ACC_W+1:0] t_q [TILE_OUT][TILE_IN];
  logic signed [ACC_W+3:0] y_d [TILE_OUT][TILE_OUT];
  logic signed [ACC_W+3:0] y_sh [TILE_OUT][TILE_OUT];
  logic [31:0]             out_data_d;

  assign in_ready = (state == ST_ACC);

  // Column j of the accumulator feeds one row-stage transform: T(:,j) = A^T * acc(:,j)
  for (genvar j = 0; j < TILE_IN; j++) begin : g_row
    wino_1d_out #(.W(ACC_W)) u_row (
      .a  (acc[j]),
      .b  (acc[TILE_IN + j]),
      .c  (acc[2*TILE_IN + j]),
      .d  (acc[3*TILE_IN + j]),
      .y0 (t_d[0][j]),
      .y1 (t_d[1][j])
    );
  end

  for (genvar i = 0; i < TILE_OUT; i++) begin : g_col
    wino_1d_out #(.W(ACC_W+2)) u_col (
      .a  (t_q[i][0]),
      .b  (t_q[i][1]),
      .c  (t_q[i][2]),
      .d  (t_q[i][3]),
      .y0 (y_d[i][0]),
      .y1 (y_d[i][1])
    );
  end

  always_comb begin
    out_data_d = '0;
    for (int unsigned i = 0; i < TILE_OUT; i++) begin
      for (int unsigned j = 0; j < TILE_OUT; j++) begin
        y_sh[i][j] = y_d[i][j] >>> shift_q;
        out_data_d[8*(2*i+j) +: 8] = sat_int8(64'(y_sh[i][j]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      first     <= 1'b1;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        acc[k] <= '0;
      end
      for (int unsigned i = 0; i < TILE_OUT; i++) begin
        for (int unsigned j = 0; j < TILE_IN; j++) begin
          t_q[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            // First beat of a tile overwrites rather than adds, so no clear cycle is needed
            for (int unsigned k = 0; k < NUM_ELEM; k++) begin
              acc[k] <= (first ? '0 : acc[k])
                        + ACC_W'(signed'(in_data[PROD_W*k +: PROD_W]));
            end
            first <= 1'b0;
            if (in_last) begin
              shift_q <= shift;
              state   <= ST_ROW;
            end
          end
        end
        ST_ROW: begin
          t_q   <= t_d;
          state <= ST_COL;
        end
        ST_COL: begin
          out_data  <= out_data_d;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            first     <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_output_trans.sv
// Directed and randomised checks of output_trans against hand-computed tiles
// and an A^T*M*A reference with requantisation.
module tb_output_trans;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [16*PROD_W-1:0] in_data;
  logic [3:0]           shift;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;

  int checks = 0;
  int errors = 0;

  output_trans #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [16*PROD_W-1:0] all_m(input int v);
    logic [16*PROD_W-1:0] d;
    for (int k = 0; k < 16; k++) d[PROD_W*k +: PROD_W] = PROD_W'(v);
    return d;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_beat(input logic [16*PROD_W-1:0] d, input logic last, input logic [3:0] sh);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    shift    = sh;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    shift    = ~sh;
    in_data  = all_m(16'h5A5A);
  endtask

  task automatic recv(input int stall, output logic [31:0] d, output logic ok);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    d  = out_data;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    shift = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%h required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ones;
    send_beat(all_m(1), 1'b1, 4'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge1: out_valid=%0b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge2: out_valid=%0b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h01FDFD09) begin
      errors++;
      $display("FAIL single_ones: out_valid=%0b out_data=%h required 1 01fdfd09", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_multi_beat;
    logic [31:0] d;
    logic ok;
    send_beat(all_m(1), 1'b0, 4'd7);
    send_beat(all_m(1), 1'b0, 4'd9);
    send_beat(all_m(1), 1'b1, 4'd1);
    recv(0, d, ok);
    checks++;
    if (ok !== 1'b1 || d !== 32'h01FBFB0D) begin
      errors++;
      $display("FAIL multi_beat: valid=%0b out_data=%h required 1 01fbfb0d", ok, d);
    end
  endtask

  task automatic test_saturation;
    int          pos [8] = '{0, 0, 5, 5, 5, 5, 0, 0};
    int          val [8] = '{1000, -1000, 127, -128, 128, -129, 32767, -32768};
    logic [3:0]  sh  [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15};
    logic [31:0] ex  [8] = '{32'h0000007F, 32'h00000080, 32'h7F7F7F7F, 32'h80808080,
                             32'h7F7F7F7F, 32'h80808080, 32'h00000000, 32'h000000FF};
    logic [16*PROD_W-1:0] d;
    logic [31:0] q;
    logic ok;
    for (int t = 0; t < 8; t++) begin
      d = '0;
      d[PROD_W*pos[t] +: PROD_W] = PROD_W'(val[t]);
      send_beat(d, 1'b1, sh[t]);
      recv(0, q, ok);
      checks++;
      if (ok !== 1'b1 || q !== ex[t]) begin
        errors++;
        $display("FAIL saturation_%0d: valid=%0b out_data=%h required 1 %h", t, ok, q, ex[t]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [16*PROD_W-1:0] d;
    logic [31:0] q;
    logic ok;
    d = '0;
    d[PROD_W*0 +: PROD_W] = 16'd5;
    send_beat(d, 1'b1, 4'd0);
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = all_m(7);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00000005 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: out_valid=%0b out_data=%h in_ready=%0b required 1 00000005 0",
                 c, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    send_beat(all_m(1), 1'b1, 4'd0);
    recv(0, q, ok);
    checks++;
    if (ok !== 1'b1 || q !== 32'h01FDFD09) begin
      errors++;
      $display("FAIL backpressure_next_tile: valid=%0b out_data=%h required 1 01fdfd09", ok, q);
    end
  endtask

  task automatic test_reset_mid_tile;
    logic [31:0] q;
    logic ok;
    send_beat(all_m(3), 1'b0, 4'd0);
    send_beat(all_m(3), 1'b0, 4'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_tile: in_ready=%0b out_valid=%0b out_data=%h required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(all_m(1), 1'b1, 4'd0);
    recv(0, q, ok);
    checks++;
    if (ok !== 1'b1 || q !== 32'h01FDFD09) begin
      errors++;
      $display("FAIL reset_fresh_tile: valid=%0b out_data=%h required 1 01fdfd09", ok, q);
    end
  endtask

  task automatic test_random;
    int at [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    int amps [3] = '{50, 2000, 32767};
    longint acc [16];
    longint w [16];
    logic signed [ACC_W-1:0] w24;
    longint y, ys;
    logic [31:0] ex, q;
    logic [16*PROD_W-1:0] d;
    logic [3:0] sh;
    logic ok;
    int len, amp, v;
    for (int t = 0; t < 8; t++) begin
      len = (t == 0) ? 1 : (t == 1) ? 256 : int'($urandom_range(2, 40));
      amp = amps[$urandom_range(0, 2)];
      sh  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) acc[k] = 0;
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < 16; k++) begin
          v = int'($urandom_range(0, 2*amp)) - amp;
          acc[k] += v;
          d[PROD_W*k +: PROD_W] = PROD_W'(v);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(d, (b == len-1), sh);
      end
      for (int k = 0; k < 16; k++) begin
        w24  = ACC_W'(acc[k]);
        w[k] = w24;
      end
      ex = '0;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          y = 0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              y += longint'(at[i][r]) * w[4*r+c] * longint'(at[j][c]);
          ys = y >>> sh;
          ex[8*(2*i+j) +: 8] = (ys > 127) ? 8'h7F : (ys < -128) ? 8'h80 : ys[7:0];
        end
      end
      recv(int'($urandom_range(0, 3)), q, ok);
      checks++;
      if (ok !== 1'b1 || q !== ex) begin
        errors++;
        $display("FAIL random_tile_%0d: valid=%0b out_data=%h required 1 %h (len=%0d shift=%0d)",
                 t, ok, q, ex, len, sh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ones();
    test_multi_beat();
    test_saturation();
    test_backpressure();
    test_reset_mid_tile();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
